// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer_if
//  Purpose  : Decoder <-> program-counter sequencer bus.
//  Signals  : ena, op, operand        (decoder -> sequencer)
//             pc, depth, stack_full,
//             stack_empty, ovf_err,
//             udf_err                 (sequencer -> decoder / imem)
//  Modports : master = decoder side, slave = sequencer side
//  Revision : 1.0  initial release
// ============================================================================
interface pc_sequencer_if #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    logic                ena;
    logic [2:0]          op;
    logic [PC_WIDTH-1:0] operand;
    logic [PC_WIDTH-1:0] pc;
    logic [DEPTH_W-1:0]  depth;
    logic                stack_full;
    logic                stack_empty;
    logic                ovf_err;
    logic                udf_err;

    modport master (
        output ena, op, operand,
        input  pc, depth, stack_full, stack_empty, ovf_err, udf_err
    );

    modport slave (
        input  ena, op, operand,
        output pc, depth, stack_full, stack_empty, ovf_err, udf_err
    );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Registered program counter driven by a 3-bit opcode, with
//             relative branches and an optional call/return stack with
//             sticky overflow/underflow flags.
//  Ports    : clk    - rising-edge clock
//             rst_n  - asynchronous active-low reset
//             bus    - pc_sequencer_if.slave (ena/op/operand in;
//                      pc/depth/stack_full/stack_empty/ovf_err/udf_err out)
//  Options  : PC_STACK_EN - when defined, builds the call/return stack;
//             otherwise CALL acts as JUMP, RET as HOLD and stack status
//             outputs are tied off.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input wire            clk,
    input wire            rst_n,
    pc_sequencer_if.slave bus
);
    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);

    localparam logic [2:0] c_OP_HOLD    = 3'b000;
    localparam logic [2:0] c_OP_INC     = 3'b001;
    localparam logic [2:0] c_OP_JUMP    = 3'b010;
    localparam logic [2:0] c_OP_BRANCH  = 3'b011;
    localparam logic [2:0] c_OP_CALL    = 3'b100;
    localparam logic [2:0] c_OP_RET     = 3'b101;
    localparam logic [2:0] c_OP_CLRERR  = 3'b110;
    localparam logic [2:0] c_OP_SOFTRST = 3'b111;

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign bus.pc   = pc_q;

`ifdef PC_STACK_EN
    localparam int ADDR_W = $clog2(STACK_DEPTH);

    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                udf_q, udf_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic [DEPTH_W-1:0]  w_depth_m1;
    logic [ADDR_W-1:0]   w_push_idx;
    logic [ADDR_W-1:0]   w_top_idx;

    assign w_full     = (depth_q == DEPTH_W'(STACK_DEPTH));
    assign w_empty    = (depth_q == '0);
    assign w_depth_m1 = depth_q - {{(DEPTH_W-1){1'b0}}, 1'b1};
    // Push writes slot depth, pop reads slot depth-1; both are guarded by
    // full/empty so the truncation to ADDR_W never aliases a valid entry.
    assign w_push_idx = depth_q[ADDR_W-1:0];
    assign w_top_idx  = w_depth_m1[ADDR_W-1:0];

    assign bus.depth       = depth_q;
    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.ovf_err     = ovf_q;
    assign bus.udf_err     = udf_q;
`else
    assign bus.depth       = {DEPTH_W{1'b0}};
    assign bus.stack_full  = 1'b0;
    assign bus.stack_empty = 1'b1;
    assign bus.ovf_err     = 1'b0;
    assign bus.udf_err     = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_q;
`ifdef PC_STACK_EN
        depth_d = depth_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        w_push  = 1'b0;
`endif
        if (bus.ena) begin
            case (bus.op)
                c_OP_HOLD:   pc_d = pc_q;
                c_OP_INC:    pc_d = w_pc_inc;
                c_OP_JUMP:   pc_d = bus.operand;
                // Two's-complement add is identical for signed offsets once
                // truncated to PC_WIDTH, so wrap in both directions is free.
                c_OP_BRANCH: pc_d = pc_q + bus.operand;
                c_OP_CALL: begin
`ifdef PC_STACK_EN
                    if (w_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        w_push  = 1'b1;
                        depth_d = depth_q + {{(DEPTH_W-1){1'b0}}, 1'b1};
                        pc_d    = bus.operand;
                    end
`else
                    pc_d = bus.operand;
`endif
                end
                c_OP_RET: begin
`ifdef PC_STACK_EN
                    if (w_empty) begin
                        udf_d = 1'b1;
                    end else begin
                        pc_d    = stack_q[w_top_idx];
                        depth_d = w_depth_m1;
                    end
`endif
                end
                c_OP_CLRERR: begin
`ifdef PC_STACK_EN
                    ovf_d = 1'b0;
                    udf_d = 1'b0;
`endif
                end
                c_OP_SOFTRST: begin
                    pc_d = '0;
`ifdef PC_STACK_EN
                    depth_d = '0;
                    ovf_d   = 1'b0;
                    udf_d   = 1'b0;
`endif
                end
                default: pc_d = pc_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
`ifdef PC_STACK_EN
            depth_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
`endif
        end else begin
            pc_q    <= pc_d;
`ifdef PC_STACK_EN
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
`endif
        end
    end

`ifdef PC_STACK_EN
    // Stack contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            stack_q[w_push_idx] <= w_pc_inc;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Self-checking bench for pc_sequencer (PC_WIDTH=8,
//             STACK_DEPTH=4). Works with PC_STACK_EN defined or undefined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;
    localparam int PW = 8;
    localparam int SD = 4;

    localparam logic [2:0] OP_HOLD    = 3'b000;
    localparam logic [2:0] OP_INC     = 3'b001;
    localparam logic [2:0] OP_JUMP    = 3'b010;
    localparam logic [2:0] OP_BRANCH  = 3'b011;
    localparam logic [2:0] OP_CALL    = 3'b100;
    localparam logic [2:0] OP_RET     = 3'b101;
    localparam logic [2:0] OP_CLRERR  = 3'b110;
    localparam logic [2:0] OP_SOFTRST = 3'b111;

`ifdef PC_STACK_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pc_sequencer_if #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) bus ();

    pc_sequencer #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [PW-1:0] m_pc;
    logic [PW-1:0] m_stk[$];
    bit            m_ovf;
    bit            m_udf;

    task automatic model_reset();
        m_pc = '0;
        m_stk.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input bit en, input logic [2:0] op, input logic [PW-1:0] opd);
        int t;
        if (!en) return;
        case (op)
            OP_INC:    m_pc = m_pc + 8'd1;
            OP_JUMP:   m_pc = opd;
            OP_BRANCH: begin
                t = int'(m_pc) + int'($signed(opd));
                m_pc = t[PW-1:0];
            end
            OP_CALL: begin
                if (!STK) m_pc = opd;
                else if (m_stk.size() == SD) m_ovf = 1'b1;
                else begin
                    m_stk.push_back(m_pc + 8'd1);
                    m_pc = opd;
                end
            end
            OP_RET: begin
                if (STK) begin
                    if (m_stk.size() == 0) m_udf = 1'b1;
                    else m_pc = m_stk.pop_back();
                end
            end
            OP_CLRERR: begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
            OP_SOFTRST: model_reset();
            default: ;
        endcase
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},    32'(bus.pc),          32'(m_pc));
        chk({tag, ".depth"}, 32'(bus.depth),       m_stk.size());
        chk({tag, ".full"},  32'(bus.stack_full),  32'(STK && m_stk.size() == SD));
        chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(m_stk.size() == 0));
        chk({tag, ".ovf"},   32'(bus.ovf_err),     32'(m_ovf));
        chk({tag, ".udf"},   32'(bus.udf_err),     32'(m_udf));
    endtask

    task automatic expect_state(input string tag, input int pc, input int dep,
                                input int ovf, input int udf);
        chk({tag, ".pc"},    32'(bus.pc),          pc);
        chk({tag, ".depth"}, 32'(bus.depth),       dep);
        chk({tag, ".full"},  32'(bus.stack_full),  32'(dep == SD));
        chk({tag, ".empty"}, 32'(bus.stack_empty), 32'(dep == 0));
        chk({tag, ".ovf"},   32'(bus.ovf_err),     ovf);
        chk({tag, ".udf"},   32'(bus.udf_err),     udf);
    endtask

    // Drive one op for one edge, then sample 1 time unit after the edge.
    task automatic step(input bit en, input logic [2:0] op, input logic [PW-1:0] opd);
        bus.ena     = en;
        bus.op      = op;
        bus.operand = opd;
        @(posedge clk);
        #1;
        model_step(en, op, opd);
    endtask

    typedef struct {
        bit          ena;
        logic [2:0]  op;
        logic [7:0]  operand;
        logic [7:0]  exp_pc;
    } vec_t;

    vec_t vt[16];

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        bus.ena     = 1'b0;
        bus.op      = OP_HOLD;
        bus.operand = '0;
        model_reset();

        vt[0]  = '{1'b1, OP_INC,    8'h00, 8'h01};
        vt[1]  = '{1'b1, OP_INC,    8'h00, 8'h02};
        vt[2]  = '{1'b1, OP_INC,    8'h00, 8'h03};
        vt[3]  = '{1'b1, OP_JUMP,   8'hFE, 8'hFE};
        vt[4]  = '{1'b1, OP_INC,    8'h00, 8'hFF};
        vt[5]  = '{1'b1, OP_INC,    8'h00, 8'h00};
        vt[6]  = '{1'b1, OP_JUMP,   8'h10, 8'h10};
        vt[7]  = '{1'b1, OP_BRANCH, 8'hF8, 8'h08};
        vt[8]  = '{1'b1, OP_BRANCH, 8'h7F, 8'h87};
        vt[9]  = '{1'b1, OP_JUMP,   8'h02, 8'h02};
        vt[10] = '{1'b1, OP_BRANCH, 8'hFC, 8'hFE};
        vt[11] = '{1'b0, OP_INC,    8'h00, 8'hFE};
        vt[12] = '{1'b0, OP_INC,    8'h00, 8'hFE};
        vt[13] = '{1'b0, OP_JUMP,   8'h33, 8'hFE};
        vt[14] = '{1'b1, OP_HOLD,   8'h55, 8'hFE};
        vt[15] = '{1'b1, OP_CLRERR, 8'h00, 8'hFE};

        // Reset state
        @(posedge clk);
        @(posedge clk);
        #1;
        expect_state("reset", 0, 0, 0, 0);
        rst_n = 1'b1;

        // Table-driven basic ops
        for (int i = 0; i < 16; i++) begin
            step(vt[i].ena, vt[i].op, vt[i].operand);
            expect_state($sformatf("vec%0d", i), int'(vt[i].exp_pc), 0, 0, 0);
        end

        // Call/return corner sequences
        step(1'b1, OP_JUMP, 8'h20); expect_state("j20", 'h20, 0, 0, 0);
`ifdef PC_STACK_EN
        step(1'b1, OP_CALL, 8'h40); expect_state("call40", 'h40, 1, 0, 0);
        step(1'b1, OP_CALL, 8'h50); expect_state("call50", 'h50, 2, 0, 0);
        step(1'b1, OP_RET,  8'h00); expect_state("ret1",   'h41, 1, 0, 0);
        step(1'b1, OP_RET,  8'h00); expect_state("ret2",   'h21, 0, 0, 0);
        step(1'b1, OP_JUMP, 8'h00); expect_state("j00",    0, 0, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, OP_CALL, 8'(i));
            expect_state($sformatf("fill%0d", i), i, i, 0, 0);
        end
        step(1'b1, OP_CALL, 8'h05); expect_state("ovf",    4, 4, 1, 0);
        for (int i = 4; i >= 1; i--) begin
            step(1'b1, OP_RET, 8'h00);
            expect_state($sformatf("drain%0d", i), i, i - 1, 1, 0);
        end
        step(1'b1, OP_RET,    8'h00); expect_state("udf",    1, 0, 1, 1);
        step(1'b1, OP_RET,    8'h00); expect_state("udf2",   1, 0, 1, 1);
        step(1'b1, OP_CLRERR, 8'h00); expect_state("clrerr", 1, 0, 0, 0);
        step(1'b1, OP_CALL,   8'h70); expect_state("call70", 'h70, 1, 0, 0);
        step(1'b1, OP_RET,    8'h00); expect_state("ret70",  2, 0, 0, 0);
        step(1'b1, OP_RET,    8'h00); expect_state("udf3",   2, 0, 0, 1);
        step(1'b1, OP_SOFTRST,8'h00); expect_state("softrst",0, 0, 0, 0);
`else
        step(1'b1, OP_CALL, 8'h40); expect_state("call40", 'h40, 0, 0, 0);
        step(1'b1, OP_RET,  8'h00); expect_state("ret_nop",'h40, 0, 0, 0);
        step(1'b1, OP_SOFTRST,8'h00); expect_state("softrst",0, 0, 0, 0);
`endif

        // Asynchronous reset mid-cycle after two calls
        step(1'b1, OP_CALL, 8'h10);
        step(1'b1, OP_CALL, 8'h20);
        check_model("pre_arst");
        bus.ena = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("arst", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();

        // Randomized ops against the reference model
        for (int i = 0; i < 600; i++) begin
            logic [2:0] op;
            bit en;
            op = 3'($urandom_range(0, 7));
            if (op == OP_SOFTRST && $urandom_range(0, 4) != 0) op = OP_CALL;
            en = ($urandom_range(0, 9) != 0);
            step(en, op, 8'($urandom));
            check_model($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
